nv_ram_rwsthp_param: RTL and testbench
======================================

Name: nv_ram_rwsthp_param

Overview:
- Parametrised two-port (1R/1W) flop/BRAM array with registered read address, output-enable data register and external bypass mux.
- Successor to the fixed-size rwsthp RAM macros. Adds width/depth parameters, selectable read-during-write forwarding and a post-reset zero-init sweep.
- Also adds a read-valid indicator and sticky out-of-range address detection.
- Used as the generic backing store for small NVDLA FIFOs and lookup tables on FPGA builds.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 19, number of entries (2..2^AW).
- AW, 5, address width; must satisfy 2^AW >= DEPTH.
- RDW_MODE, 1, read-during-write on same address: 1 = forward new write data, 0 = return old array data.
- INIT_EN, 1, 1 = zero every entry after reset before accepting traffic; 0 = array usable immediately.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ra  in  AW  read address.
- re  in  1  read address enable.
- ore  in  1  output register enable.
- dout  out  DW  registered read data.
- dout_vld  out  1  dout holds data from an accepted read or from the bypass path.
- wa  in  AW  write address.
- we  in  1  write enable.
- di  in  DW  write data.
- byp_sel  in  1  select dbyp instead of array data.
- dbyp  in  DW  bypass data.
- pwrbus_ram_pd  in  32  power-down bus; functionally ignored.
- init_done  out  1  array initialised; traffic accepted.
- addr_err  out  1  sticky: an out-of-range ra/wa was presented with re/we.

Behaviour:
- Reset (async assert, sync release): dout=0, dout_vld=0, ra_d=0, rd_pend=0, addr_err=0, init pointer=0. FSM enters INIT if INIT_EN=1, else READY. Array contents are not reset asynchronously.
- FSM states:
  - INIT: each cycle writes 0 to M[ptr] and increments ptr. When ptr==DEPTH-1 the FSM goes to READY. INIT takes exactly DEPTH cycles after reset release.
  - READY: terminal state until rst.
  - init_done = (state==READY).
- During INIT, re, we and ore are ignored: no array write, ra_d/dout hold, addr_err is not updated.
- Write (READY):
  - we && wa<DEPTH: M[wa]<=di at the clock edge.
  - we && wa>=DEPTH: write dropped, addr_err<=1.
- Read address stage (READY):
  - re && ra<DEPTH: ra_d<=ra, rd_pend<=1.
  - re && ra>=DEPTH: ra_d and rd_pend unchanged, addr_err<=1.
  - rd_pend stays 1 until rst. ra_d is held, so ore may resample repeatedly.
- Output stage (READY), when ore=1, dout<=sel:
  - byp_sel=1: sel = dbyp (highest priority).
  - else RDW_MODE=1 && we && wa==ra_d && wa<DEPTH: sel = di (forwarded).
  - else: sel = M[ra_d] (pre-edge contents).
  - Also on ore: dout_vld<=byp_sel | rd_pend.
  - ore=0: dout and dout_vld hold.
- Latency: re sampled at edge N, ore at edge N+1 gives dout valid after edge N+1 (2 cycles from ra presentation). Bypass: dbyp appears 1 cycle after ore.
- Simultaneous re and we to the same address in one cycle: ra_d captures the address. A later ore returns the new data in both RDW modes.
- Simultaneous out-of-range re and we: one addr_err set; the in-range operation, if any, proceeds.
- addr_err clears only on rst.
- Mid-operation rst: outputs return to reset values immediately; the INIT sweep reruns when INIT_EN=1.

Test Plan:
- INIT_EN=1, DEPTH=19: release rst, then hold re/we/ore=1 with wa=3, di=0xAAAA5555. init_done must rise after exactly 19 cycles; M[3] reads back 0 (write ignored during INIT); dout stays 0.
- Write 0x12345678 to addr 7, then re ra=7, then ore. dout=0x12345678 and dout_vld=1 one cycle after ore; dout holds when ore=0.
- With ra_d=5 and M[5]=0x11111111, drive we wa=5 di=0x22222222 with ore in the same cycle. RDW_MODE=1 gives dout=0x22222222; RDW_MODE=0 gives 0x11111111, and a following ore gives 0x22222222.
- byp_sel=1, dbyp=0xDEADBEEF, ore=1 with a same-address write in flight. dout=0xDEADBEEF, dout_vld=1, even before any re.
- re with ra=25 and we with wa=20 (DEPTH=19). addr_err=1 and stays 1; ra_d is unchanged and prior read data is still returned; no entry is corrupted.
- Assert rst during READY with dout=0x12345678. Same cycle: dout=0, dout_vld=0, addr_err=0, init_done=0. After reinit, M[7] reads 0.

Source files
------------

// File: rtl/nv_ram_rwsthp_param.sv
// rtl/nv_ram_rwsthp_param.sv - parametrised 1R/1W RAM with registered read address, output register and bypass
module nv_ram_rwsthp_param #(
  parameter int DW       = 32,
  parameter int DEPTH    = 19,
  parameter int AW       = 5,
  parameter int RDW_MODE = 1,
  parameter int INIT_EN  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          re,
  input  logic          ore,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [DW-1:0] di,
  input  logic          byp_sel,
  input  logic [DW-1:0] dbyp,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic          init_done,
  output logic          addr_err
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INIT_EN != 0) ? S_INIT : S_READY;

  state_t        state;
  state_t        state_nxt;
  logic          init_wr;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ra_d;
  logic          rd_pend;
  logic [DW-1:0] mem [0:DEPTH-1];
  logic          ra_ok;
  logic          wa_ok;
  logic          fwd;
  logic [DW-1:0] sel;

  // The power-down bus has no functional effect on this model of the macro.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  assign ra_ok = ({1'b0, ra} < DEPTH_L);
  assign wa_ok = ({1'b0, wa} < DEPTH_L);

  // State register: the zero-init sweep reruns after every reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  // Next state: leave INIT once the last entry is being cleared.
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && ptr == LAST) state_nxt = S_READY;
  end

  // FSM outputs: traffic is only accepted in READY.
  always_comb begin
    init_done = (state == S_READY);
    init_wr   = (state == S_INIT);
  end

  // Sweep pointer walks every entry once during INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (init_wr) ptr <= ptr + AW'(1);
  end

  // Array write port, shared between the init sweep and user writes; no reset on contents.
  always_ff @(posedge clk) begin
    if (init_wr)                      mem[ptr] <= '0;
    else if (init_done && we && wa_ok) mem[wa]  <= di;
  end

  // Read address register; out-of-range reads leave the previous address in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_d    <= '0;
      rd_pend <= 1'b0;
    end else if (init_done && re && ra_ok) begin
      ra_d    <= ra;
      rd_pend <= 1'b1;
    end
  end

  // Output mux: bypass wins, then optional same-address forwarding, else pre-edge array data.
  always_comb begin
    fwd = (RDW_MODE != 0) && we && wa_ok && (wa == ra_d);
    if (byp_sel)  sel = dbyp;
    else if (fwd) sel = di;
    else          sel = mem[ra_d];
  end

  // Output data register, loaded only when ore is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (init_done && ore) begin
      dout     <= sel;
      dout_vld <= byp_sel | rd_pend;
    end
  end

  // Sticky out-of-range detection on either port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  addr_err <= 1'b0;
    else if (init_done && ((re && !ra_ok) || (we && !wa_ok))) addr_err <= 1'b1;
  end

endmodule

// File: tb/tb_nv_ram_rwsthp_param.sv
// tb/tb_nv_ram_rwsthp_param.sv - self-checking bench for nv_ram_rwsthp_param in both read-during-write modes
module tb_nv_ram_rwsthp_param;

  localparam int D = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra = '0, wa = '0;
  logic        re = 1'b0, we = 1'b0, ore = 1'b0, byp_sel = 1'b0;
  logic [31:0] di = '0, dbyp = '0;
  logic [31:0] pwrbus_ram_pd = '0;

  logic [31:0] dout1, dout0;
  logic        vld1, vld0, idone1, idone0, err1, err0;

  int passed = 0;
  int total  = 0;
  bit run    = 1'b0;

  always #5 clk = ~clk;

  nv_ram_rwsthp_param #(.DW(32), .DEPTH(D), .AW(5), .RDW_MODE(1), .INIT_EN(1)) dut1 (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout1), .dout_vld(vld1),
    .wa(wa), .we(we), .di(di), .byp_sel(byp_sel), .dbyp(dbyp),
    .pwrbus_ram_pd(pwrbus_ram_pd), .init_done(idone1), .addr_err(err1));

  nv_ram_rwsthp_param #(.DW(32), .DEPTH(D), .AW(5), .RDW_MODE(0), .INIT_EN(1)) dut0 (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout0), .dout_vld(vld0),
    .wa(wa), .we(we), .di(di), .byp_sel(byp_sel), .dbyp(dbyp),
    .pwrbus_ram_pd(pwrbus_ram_pd), .init_done(idone0), .addr_err(err0));

  // Behavioural model: an array plus the few pieces of visible state.
  logic [31:0] m_mem [D];
  int          m_left;
  bit          m_ready;
  int          m_ra_d;
  bit          m_pend;
  logic [31:0] m_dout [2];
  bit          m_vld;
  bit          m_err;

  function automatic logic [31:0] msel(input int mode);
    if (byp_sel) return dbyp;
    if (mode == 1 && we && int'(wa) < D && int'(wa) == m_ra_d) return di;
    return m_mem[m_ra_d];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left    <= D;
      m_ready   <= 1'b0;
      m_ra_d    <= 0;
      m_pend    <= 1'b0;
      m_dout[0] <= '0;
      m_dout[1] <= '0;
      m_vld     <= 1'b0;
      m_err     <= 1'b0;
    end else if (!m_ready) begin
      m_mem[D - m_left] <= '0;
      m_left            <= m_left - 1;
      m_ready           <= (m_left == 1);
    end else begin
      if (ore) begin
        m_dout[0] <= msel(0);
        m_dout[1] <= msel(1);
        m_vld     <= byp_sel | m_pend;
      end
      if ((re && int'(ra) >= D) || (we && int'(wa) >= D)) m_err <= 1'b1;
      if (re && int'(ra) < D) begin
        m_ra_d <= int'(ra);
        m_pend <= 1'b1;
      end
      if (we && int'(wa) < D) m_mem[wa] <= di;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("cyc_dout_m1", dout1, m_dout[1]);
      chk("cyc_dout_m0", dout0, m_dout[0]);
      chk("cyc_vld_m1", {31'd0, vld1}, {31'd0, m_vld});
      chk("cyc_vld_m0", {31'd0, vld0}, {31'd0, m_vld});
      chk("cyc_idone_m1", {31'd0, idone1}, {31'd0, m_ready});
      chk("cyc_idone_m0", {31'd0, idone0}, {31'd0, m_ready});
      chk("cyc_err_m1", {31'd0, err1}, {31'd0, m_err});
      chk("cyc_err_m0", {31'd0, err0}, {31'd0, m_err});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    re = 1'b0; we = 1'b0; ore = 1'b0; byp_sel = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (idone1 && idone0) begin
        n = c;
        break;
      end
    end
    idle();
    chk(name, n, 19);
  endtask

  task automatic rd(input logic [4:0] a);
    idle(); re = 1'b1; ra = a; cyc();
    idle(); ore = 1'b1; cyc();
    idle();
  endtask

  initial begin
    // Reset state
    cyc();
    chk("rst_dout", dout1, 32'h0);
    chk("rst_vld", {31'd0, vld1}, 32'h0);
    chk("rst_idone", {31'd0, idone1}, 32'h0);
    chk("rst_err", {31'd0, err0}, 32'h0);

    // INIT with traffic held active; must be ignored
    rst = 1'b0;
    run = 1'b1;
    re = 1'b1; we = 1'b1; ore = 1'b1; wa = 5'd3; ra = 5'd3; di = 32'hAAAA5555;
    wait_init("init_cycles");
    chk("init_dout_held", dout1, 32'h0);
    chk("init_err_held", {31'd0, err1}, 32'h0);

    // ore before any read and without bypass: not valid
    ore = 1'b1; cyc(); idle();
    chk("no_read_vld", {31'd0, vld1}, 32'h0);

    // Bypass with same-address write in flight, before any accepted read
    byp_sel = 1'b1; dbyp = 32'hDEADBEEF; ore = 1'b1; we = 1'b1; wa = 5'd0; di = 32'h5A5A5A5A;
    cyc(); idle();
    chk("byp_dout_m1", dout1, 32'hDEADBEEF);
    chk("byp_dout_m0", dout0, 32'hDEADBEEF);
    chk("byp_vld", {31'd0, vld1}, 32'h1);

    // M[3] untouched by the ignored INIT-time write
    rd(5'd3);
    chk("init_m3_zero", dout1, 32'h0);
    chk("init_m3_vld", {31'd0, vld1}, 32'h1);

    // Basic write/read, then hold
    we = 1'b1; wa = 5'd7; di = 32'h12345678; cyc();
    rd(5'd7);
    chk("rd7_dout", dout1, 32'h12345678);
    chk("rd7_vld", {31'd0, vld0}, 32'h1);
    ra = 5'd2; cyc(); cyc();
    chk("rd7_hold", dout0, 32'h12345678);

    // Read-during-write on the registered address
    we = 1'b1; wa = 5'd5; di = 32'h11111111; cyc();
    idle(); re = 1'b1; ra = 5'd5; cyc();
    idle(); we = 1'b1; wa = 5'd5; di = 32'h22222222; ore = 1'b1; cyc();
    idle();
    chk("rdw_m1", dout1, 32'h22222222);
    chk("rdw_m0", dout0, 32'h11111111);
    chk("rdw_model_m0", m_dout[0], 32'h11111111);
    ore = 1'b1; cyc(); idle();
    chk("rdw_m0_next", dout0, 32'h22222222);

    // Same-cycle re and we to one address: new data in both modes
    re = 1'b1; ra = 5'd11; we = 1'b1; wa = 5'd11; di = 32'hCAFE0011; cyc();
    idle(); ore = 1'b1; cyc(); idle();
    chk("rew_same_m1", dout1, 32'hCAFE0011);
    chk("rew_same_m0", dout0, 32'hCAFE0011);

    // Out-of-range read and write
    idle(); re = 1'b1; ra = 5'd7; cyc();
    idle(); re = 1'b1; ra = 5'd25; we = 1'b1; wa = 5'd20; di = 32'hFFFFFFFF; cyc();
    idle();
    chk("oor_err", {31'd0, err1}, 32'h1);
    ore = 1'b1; cyc(); idle();
    chk("oor_ra_d_held", dout1, 32'h12345678);
    chk("oor_model_dout", m_dout[1], 32'h12345678);
    rd(5'd1);
    chk("oor_m1_clean", dout0, 32'h0);
    rd(5'd4);
    chk("oor_m4_clean", dout1, 32'h0);

    // Out-of-range read alongside a valid write: write proceeds
    re = 1'b1; ra = 5'd31; we = 1'b1; wa = 5'd9; di = 32'h0BADF00D; cyc();
    rd(5'd9);
    chk("oor_we_ok", dout1, 32'h0BADF00D);
    chk("err_sticky", {31'd0, err0}, 32'h1);

    // Reset during READY
    rd(5'd7);
    chk("pre_rst_dout", dout1, 32'h12345678);
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", dout1, 32'h0);
    chk("mid_rst_vld", {31'd0, vld1}, 32'h0);
    chk("mid_rst_err", {31'd0, err1}, 32'h0);
    chk("mid_rst_idone", {31'd0, idone0}, 32'h0);
    cyc();
    rst = 1'b0;
    wait_init("reinit_cycles");
    rd(5'd7);
    chk("reinit_m7", dout1, 32'h0);
    chk("reinit_m7_m0", dout0, 32'h0);
    chk("reinit_vld", {31'd0, vld1}, 32'h1);
    cyc();

    run = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
